z80_mem_responder: RTL and testbench
====================================

Name: z80_mem_responder

Overview:
- Bus-target side of the Z80 non-M1 memory read/write cycle. Watches nMREQ/nRD/nWR/nRFSH/A from the CPU core and decodes its own address window.
- Stretches the CPU cycle with nWAIT while it runs a req/ack transaction on a backing-store port.
- Drives read data onto the data bus, and captures write data from it.
- Sits between the CPU bus and an on-chip RAM/ROM or peripheral model. Used as the memory model in system benches.

Parameters:
- BASE, 16'h0000: window base address. Only bits [15:SIZE_LOG2] are significant.
- SIZE_LOG2, 14: window size is 2**SIZE_LOG2 bytes. Legal range 1..16.
- MIN_WAIT, 1: minimum wait states inserted per access. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic runs on posedge.
- reset  in  1  reset, synchronous, active-high.
- A  in  16  CPU address bus.
- nMREQ  in  1  memory request, active-low.
- nRD  in  1  read strobe, active-low.
- nWR  in  1  write strobe, active-low.
- nRFSH  in  1  refresh indicator, active-low.
- D_in  in  8  data bus as driven by the CPU.
- D_out  out  8  read data to the data bus.
- data_out_en  out  1  responder drives the data bus.
- nWAIT  out  1  wait request to the CPU, active-low.
- mem_req  out  1  backend request.
- mem_we  out  1  backend write enable (1 = write).
- mem_addr  out  SIZE_LOG2  backend byte offset, A[SIZE_LOG2-1:0].
- mem_wdata  out  8  backend write data.
- mem_ack  in  1  backend completion; meaningful only while mem_req=1.
- mem_rdata  in  8  backend read data; valid when mem_ack=1.

Behaviour:
- Reset values: nWAIT=1, data_out_en=0, D_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, wait_cnt=0.
- Reset mid-access: same values on the next posedge. Any outstanding request is abandoned; the backend tolerates a dropped mem_req.
- Hit condition, evaluated at a posedge: nMREQ=0, nRFSH=1, and A[15:SIZE_LOG2]==BASE[15:SIZE_LOG2]. Refresh cycles and misses are ignored: no outputs change.
- CPU timing this block relies on:
  - CPU asserts nMREQ and nRD (read) at T1 negedge.
  - CPU drives write data from T1 negedge; nWR falls at T2 negedge.
  - CPU samples nWAIT at each T2/Tw negedge.
  - CPU samples read data at T3 negedge.
- States: IDLE, ACCESS, HOLD, DRAIN.
- IDLE -> ACCESS, at the first posedge with a hit (the T2 posedge):
  - mem_req<=1, mem_addr<=A offset, nWAIT<=0, wait_cnt<=0.
  - Type is decided here: nRD=0 means read (mem_we<=0); nRD=1 means write (mem_we<=1, mem_wdata<=D_in).
  - nWR is not required for the decision.
- ACCESS, each posedge:
  - wait_cnt++ (saturating at 15).
  - On mem_ack=1: mem_req<=0 and the ack is recorded. For a read, D_out<=mem_rdata.
  - Release: nWAIT<=1 at the first posedge where the ack has been recorded (this posedge or earlier) and wait_cnt+1 >= MIN_WAIT. At that posedge go to HOLD; for a read also set data_out_en<=1.
  - Result: an ack sampled k posedges after T2 gives exactly max(k, MIN_WAIT) wait states.
- ACCESS abort: nMREQ seen 1 before release (CPU reset or abort).
  - nWAIT<=1, data_out_en<=0.
  - If mem_req is still 1, go to DRAIN; otherwise go to IDLE.
- DRAIN: keep mem_req=1 until mem_ack, discard the data, then go to IDLE.
- HOLD: keep D_out and data_out_en until the posedge where nMREQ=1 or (read and nRD=1). At that posedge data_out_en<=0, go to IDLE.
  - This frees the bus by the next T1 posedge, before any CPU write drive.
- Back-to-back cycles: IDLE can accept a new hit on the posedge after leaving HOLD.
- Invariants:
  - Never data_out_en=1 while nRD=1 and the cycle is a write.
  - nWAIT=0 only in ACCESS.
  - At most one outstanding mem_req.

Decomposition:
- Shared z80 package gets:
  - typedef enum resp_state_t {IDLE, ACCESS, HOLD, DRAIN};
  - constant Z80_WAIT_CNT_W=4.
- No sub-module; a single FSM plus wait counter.

Test Plan:
- Read 16'h1234 with BASE=0, SIZE_LOG2=14, backend acking 1 cycle after mem_req with 8'hFE -> mem_addr=14'h1234, mem_we=0, 2 wait states, CPU rdata=8'hFE, data_out_en drops at next T1 posedge.
- Write 8'h67 to 16'h1234, combinational ack -> mem_we=1, mem_wdata=8'h67, exactly 1 wait state (MIN_WAIT=1), no data_out_en assertion.
- MIN_WAIT=3 with combinational ack on read of 16'h0010 -> exactly 3 wait states, mem_req high for 1 cycle only.
- Access to 16'hC000 (outside window) and a refresh cycle (nRFSH=0) -> mem_req, nWAIT, data_out_en unchanged throughout.
- Reset asserted during ACCESS with mem_req=1 -> next posedge all outputs at reset values; next read to 16'h0001 completes normally.
- nMREQ raised during ACCESS, ack arriving 2 cycles later -> nWAIT=1 at once, DRAIN holds mem_req until ack, returns to IDLE with no bus drive.

Source files
------------

// File: rtl/z80_mem_responder_pkg.sv
// Shared types for the Z80 memory-cycle responder.
// FSM encoding and wait-counter width.
package z80_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HOLD,
    DRAIN
  } resp_state_t;

  localparam int Z80_WAIT_CNT_W = 4;

endpackage

// File: rtl/z80_mem_responder.sv
// Z80 non-M1 memory cycle target: decodes a window, stretches
// the cycle with nWAIT and runs one req/ack backend transaction.
module z80_mem_responder
  import z80_mem_responder_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'h0000,
  parameter int          SIZE_LOG2 = 14,
  parameter int          MIN_WAIT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          A,
  input  logic                 nMREQ,
  input  logic                 nRD,
  input  logic                 nWR,
  input  logic                 nRFSH,
  input  logic [7:0]           D_in,
  output logic [7:0]           D_out,
  output logic                 data_out_en,
  output logic                 nWAIT,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [SIZE_LOG2-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata
);

  localparam int CW = Z80_WAIT_CNT_W;

  // A 16-bit window must compare no address bits at all.
  localparam logic [16:0] WIN     = 17'd1 << SIZE_LOG2;
  localparam logic [15:0] HI_MASK = ~(WIN[15:0] - 16'd1);
  localparam logic [CW:0] MIN_W   = (CW+1)'(MIN_WAIT);

  resp_state_t   state;
  logic [CW-1:0] wait_cnt;
  logic          acked;
  logic          is_read;

  logic          hit;
  logic          ack_now;
  logic [CW:0]   cnt_inc;
  logic [CW-1:0] cnt_sat;
  logic          release_ok;
  logic          unused_nwr;

  assign unused_nwr = nWR;

  assign hit = !nMREQ && nRFSH &&
               (((A ^ BASE) & HI_MASK) == 16'h0000);

  assign ack_now    = mem_req && mem_ack;
  assign cnt_inc    = {1'b0, wait_cnt} + {{CW{1'b0}}, 1'b1};
  assign cnt_sat    = (&wait_cnt) ? wait_cnt : cnt_inc[CW-1:0];
  assign release_ok = (acked || ack_now) && (cnt_inc >= MIN_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      acked       <= 1'b0;
      is_read     <= 1'b0;
      nWAIT       <= 1'b1;
      data_out_en <= 1'b0;
      D_out       <= 8'h00;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state    <= ACCESS;
            mem_req  <= 1'b1;
            mem_addr <= A[SIZE_LOG2-1:0];
            nWAIT    <= 1'b0;
            wait_cnt <= '0;
            acked    <= 1'b0;
            is_read  <= !nRD;
            mem_we   <= nRD;
            if (nRD) mem_wdata <= D_in;
          end
        end
        ACCESS: begin
          if (nMREQ) begin
            nWAIT       <= 1'b1;
            data_out_en <= 1'b0;
            if (mem_req && !mem_ack) begin
              state <= DRAIN;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            wait_cnt <= cnt_sat;
            if (ack_now) begin
              mem_req <= 1'b0;
              acked   <= 1'b1;
              if (is_read) D_out <= mem_rdata;
            end
            if (release_ok) begin
              nWAIT       <= 1'b1;
              data_out_en <= is_read;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (nMREQ || (is_read && nRD)) begin
            data_out_en <= 1'b0;
            state       <= IDLE;
          end
        end
        DRAIN: begin
          // Abandoned transfer: wait out the ack, drop the data.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_mem_responder.sv
// Directed bench: a CPU bus model drives T-state sequences
// against two responders (MIN_WAIT 1 and 3) with delayed-ack backends.
module tb_z80_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic        nMREQ, nRD, nWR, nRFSH;
  logic [7:0]  D_in;

  logic [7:0]  dout1, wdata1, rdata1;
  logic        oe1, nwait1, req1, we1, ack1;
  logic [13:0] addr1;
  logic [7:0]  dout3, wdata3, rdata3;
  logic        oe3, nwait3, req3, we3, ack3;
  logic [13:0] addr3;

  int dly1, dly3, age1, age3;
  int checks = 0;
  int errors = 0;

  logic        sel;
  logic [7:0]  s_dout, s_wdata;
  logic        s_oe, s_nwait, s_req, s_we;
  logic [13:0] s_addr;

  int          r_waits, r_req;
  logic [7:0]  r_rd, r_wdata;
  logic        r_oe3, r_oe_after, r_any_oe, r_we;
  logic [13:0] r_addr;

  always #5 clk = ~clk;

  z80_mem_responder #(.BASE(16'h0000), .SIZE_LOG2(14), .MIN_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .A(A), .nMREQ(nMREQ), .nRD(nRD),
    .nWR(nWR), .nRFSH(nRFSH), .D_in(D_in), .D_out(dout1),
    .data_out_en(oe1), .nWAIT(nwait1), .mem_req(req1), .mem_we(we1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_ack(ack1),
    .mem_rdata(rdata1)
  );

  z80_mem_responder #(.BASE(16'h0000), .SIZE_LOG2(14), .MIN_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .A(A), .nMREQ(nMREQ), .nRD(nRD),
    .nWR(nWR), .nRFSH(nRFSH), .D_in(D_in), .D_out(dout3),
    .data_out_en(oe3), .nWAIT(nwait3), .mem_req(req3), .mem_we(we3),
    .mem_addr(addr3), .mem_wdata(wdata3), .mem_ack(ack3),
    .mem_rdata(rdata3)
  );

  // Backend: ack once mem_req has been high for dly posedges.
  always @(posedge clk) begin
    age1 <= req1 ? age1 + 1 : 0;
    age3 <= req3 ? age3 + 1 : 0;
  end
  assign ack1 = req1 && (age1 >= dly1);
  assign ack3 = req3 && (age3 >= dly3);

  always_comb begin
    s_dout  = sel ? dout3  : dout1;
    s_oe    = sel ? oe3    : oe1;
    s_nwait = sel ? nwait3 : nwait1;
    s_req   = sel ? req3   : req1;
    s_we    = sel ? we3    : we1;
    s_addr  = sel ? addr3  : addr1;
    s_wdata = sel ? wdata3 : wdata1;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU memory cycle, T1 through the following T1.
  task cpu_cycle(input logic [15:0] addr, input logic wr,
                 input logic [7:0] wd);
    @(negedge clk);
    A = addr; nMREQ = 1'b0; nRD = wr; D_in = wd;
    @(negedge clk);
    if (wr) nWR = 1'b0;
    r_we = s_we; r_addr = s_addr; r_wdata = s_wdata;
    r_waits = 0; r_req = 0; r_any_oe = 1'b0;
    while (!s_nwait && r_waits < 40) begin
      if (s_req) r_req++;
      r_any_oe = r_any_oe | s_oe;
      r_waits++;
      @(negedge clk);
    end
    if (s_req) r_req++;
    @(negedge clk);
    r_rd = s_dout; r_oe3 = s_oe;
    r_any_oe = r_any_oe | s_oe;
    nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    @(negedge clk);
    r_oe_after = s_oe;
  endtask

  initial begin
    reset = 1'b1; A = 16'h0000; D_in = 8'h00;
    nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
    sel = 1'b0; dly1 = 1; dly3 = 0;
    rdata1 = 8'hFE; rdata3 = 8'h5A;
    repeat (2) @(negedge clk);
    chk("rst_nwait", 16'(nwait1), 16'h1);
    chk("rst_oe", 16'(oe1), 16'h0);
    chk("rst_dout", 16'(dout1), 16'h0);
    chk("rst_req", 16'(req1), 16'h0);
    chk("rst_we", 16'(we1), 16'h0);
    chk("rst_addr", 16'(addr1), 16'h0);
    chk("rst_wdata", 16'(wdata1), 16'h0);
    reset = 1'b0;

    // read, ack one cycle after request
    cpu_cycle(16'h1234, 1'b0, 8'h00);
    chk("rd_addr", 16'(r_addr), 16'h1234);
    chk("rd_we", 16'(r_we), 16'h0);
    chk("rd_waits", 16'(r_waits), 16'd2);
    chk("rd_req_cyc", 16'(r_req), 16'd2);
    chk("rd_data", 16'(r_rd), 16'h00FE);
    chk("rd_oe_t3", 16'(r_oe3), 16'h1);
    chk("rd_oe_rel", 16'(r_oe_after), 16'h0);

    // write, combinational ack
    dly1 = 0;
    cpu_cycle(16'h1234, 1'b1, 8'h67);
    chk("wr_we", 16'(r_we), 16'h1);
    chk("wr_wdata", 16'(r_wdata), 16'h0067);
    chk("wr_addr", 16'(r_addr), 16'h1234);
    chk("wr_waits", 16'(r_waits), 16'd1);
    chk("wr_no_oe", 16'(r_any_oe), 16'h0);

    // MIN_WAIT=3 responder, combinational ack
    sel = 1'b1;
    cpu_cycle(16'h0010, 1'b0, 8'h00);
    chk("mw3_waits", 16'(r_waits), 16'd3);
    chk("mw3_req_cyc", 16'(r_req), 16'd1);
    chk("mw3_data", 16'(r_rd), 16'h005A);
    chk("mw3_oe_t3", 16'(r_oe3), 16'h1);
    chk("mw3_oe_rel", 16'(r_oe_after), 16'h0);
    sel = 1'b0;

    // miss, then refresh inside the window
    @(negedge clk);
    A = 16'hC000; nMREQ = 1'b0; nRD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("miss_quiet", 16'({req1, nwait1, oe1}), 16'b010);
    end
    nMREQ = 1'b1; nRD = 1'b1;
    @(negedge clk);
    A = 16'h0010; nMREQ = 1'b0; nRFSH = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rfsh_quiet", 16'({req1, nwait1, oe1}), 16'b010);
    end
    nMREQ = 1'b1; nRFSH = 1'b1;

    // reset during ACCESS
    dly1 = 20;
    @(negedge clk);
    A = 16'h0001; nMREQ = 1'b0; nRD = 1'b0;
    @(negedge clk);
    chk("mid_req", 16'(req1), 16'h1);
    chk("mid_nwait", 16'(nwait1), 16'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", 16'(req1), 16'h0);
    chk("mid_rst_nwait", 16'(nwait1), 16'h1);
    chk("mid_rst_oe", 16'(oe1), 16'h0);
    chk("mid_rst_dout", 16'(dout1), 16'h0);
    chk("mid_rst_we", 16'(we1), 16'h0);
    chk("mid_rst_addr", 16'(addr1), 16'h0);
    chk("mid_rst_wdata", 16'(wdata1), 16'h0);
    reset = 1'b0; nMREQ = 1'b1; nRD = 1'b1;
    dly1 = 1; rdata1 = 8'h3C;
    cpu_cycle(16'h0001, 1'b0, 8'h00);
    chk("post_rst_addr", 16'(r_addr), 16'h0001);
    chk("post_rst_waits", 16'(r_waits), 16'd2);
    chk("post_rst_data", 16'(r_rd), 16'h003C);

    // abort during ACCESS, ack two cycles after the abort
    dly1 = 2; rdata1 = 8'hAA;
    @(negedge clk);
    A = 16'h0100; nMREQ = 1'b0; nRD = 1'b0;
    @(negedge clk);
    chk("ab_req", 16'(req1), 16'h1);
    nMREQ = 1'b1; nRD = 1'b1;
    @(negedge clk);
    chk("ab_nwait", 16'(nwait1), 16'h1);
    chk("ab_drain_req", 16'(req1), 16'h1);
    chk("ab_oe", 16'(oe1), 16'h0);
    @(negedge clk);
    chk("ab_drain_req2", 16'(req1), 16'h1);
    @(negedge clk);
    chk("ab_req_done", 16'(req1), 16'h0);
    chk("ab_dout_kept", 16'(dout1), 16'h003C);
    chk("ab_oe_end", 16'(oe1), 16'h0);

    // back to IDLE: a normal read follows
    dly1 = 0; rdata1 = 8'h81;
    cpu_cycle(16'h0002, 1'b0, 8'h00);
    chk("ab_next_waits", 16'(r_waits), 16'd1);
    chk("ab_next_data", 16'(r_rd), 16'h0081);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
